// File: rtl/seg_mask_packer.sv
// Thresholds a raster stream of signed logits into 1-bit mask pixels, packs 8 per byte into a small
// output FIFO, and accumulates the mask-1 pixel count and bounding box for each frame.
module seg_mask_packer #(
    parameter int IMG_HEIGHT = 256,
    parameter int IMG_WIDTH  = 256,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1,
    localparam int COL_W = $clog2(IMG_WIDTH),
    localparam int CNT_W = $clog2(IMG_HEIGHT * IMG_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seg_in,
    input  logic                  seg_valid,
    input  logic [DATA_WIDTH-1:0] threshold,
    output logic [7:0]            mask_byte,
    output logic                  mask_valid,
    input  logic                  mask_ready,
    output logic [CNT_W-1:0]      tumor_count,
    output logic [ROW_W-1:0]      min_row,
    output logic [ROW_W-1:0]      max_row,
    output logic [COL_W-1:0]      min_col,
    output logic [COL_W-1:0]      max_col,
    output logic                  bbox_valid,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow
);

    // FIFO_DEPTH is a power of two >= 2 so the pointers wrap on their own.
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [7:0]       pack;
    logic [7:0]       packed_next;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic accept, pix_bit, byte_done, last_pix, start_frame;
    logic fifo_full, rd_en, wr_en, drop, col_last;

    // Handshake: a byte moves on a rising edge where mask_valid and mask_ready are both high;
    // mask_byte holds steady while mask_valid is high and mask_ready is low.
    assign mask_valid  = (count != '0);
    assign mask_byte   = mask_valid ? mem[rd_ptr] : 8'h00;
    assign rd_en       = mask_valid && mask_ready;
    assign fifo_full   = (count == (AW + 1)'(FIFO_DEPTH));

    assign start_frame = (state == S_IDLE) && start;
    assign accept      = (state == S_RUN) && seg_valid;
    assign pix_bit     = $signed(seg_in) > $signed(threshold);
    assign col_last    = (col == COL_W'(IMG_WIDTH - 1));
    assign last_pix    = accept && col_last && (row == ROW_W'(IMG_HEIGHT - 1));
    assign byte_done   = accept && (col[2:0] == 3'b111);
    // A read in the same cycle frees the slot, so a full FIFO only drops without one.
    assign wr_en       = byte_done && (!fifo_full || rd_en);
    assign drop        = byte_done && fifo_full && !rd_en;
    assign bbox_valid  = (tumor_count != '0);

    always_comb begin
        packed_next = pack;
        packed_next[col[2:0]] = pix_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (last_pix) state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (count == '0) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row         <= '0;
            col         <= '0;
            pack        <= '0;
            tumor_count <= '0;
            min_row     <= '1;
            max_row     <= '0;
            min_col     <= '1;
            max_col     <= '0;
            overflow    <= 1'b0;
        end else if (start_frame) begin
            row         <= '0;
            col         <= '0;
            pack        <= '0;
            tumor_count <= '0;
            min_row     <= '1;
            max_row     <= '0;
            min_col     <= '1;
            max_col     <= '0;
            overflow    <= 1'b0;
        end else begin
            if (accept) begin
                pack <= packed_next;
                if (col_last) begin
                    col <= '0;
                    row <= last_pix ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
                if (pix_bit) begin
                    tumor_count <= tumor_count + CNT_W'(1);
                    if (row < min_row) min_row <= row;
                    if (row > max_row) max_row <= row;
                    if (col < min_col) min_col <= col;
                    if (col > max_col) max_col <= col;
                end
            end
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= packed_next;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
